// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel switch debouncer.
// Channel state encoding and timer sizing live here.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HIGH         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // The timer only has to reach delay-1, so clog2 bits suffice.
    function automatic int cnt_width(input int delay);
        int w;
        w = $clog2(delay);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: synchroniser chain, debounce FSM and timer.
// Level, rise and fall are registered; rise_next feeds the shared AnyRise.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DELAY_CYCLES     = 1000000,
    parameter int SYNC_STAGES      = 2,
    parameter int RELEASE_DEBOUNCE = 1
) (
    input  logic CLOCK,
    input  logic Reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic rise_next
);

    localparam int CW = cnt_width(DELAY_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DELAY_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    state_t                 state;
    logic [CW-1:0]          cnt;

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge CLOCK) begin
        if (Reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
        end
    end

    // Same condition the FSM uses to raise rise, one cycle ahead.
    always_comb begin
        rise_next = 1'b0;
        if (state == PRESS_WAIT && s && cnt == LAST) begin
            rise_next = 1'b1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (s) begin
                        state <= PRESS_WAIT;
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state <= HIGH;
                        cnt   <= '0;
                        level <= 1'b1;
                        rise  <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HIGH: begin
                    cnt <= '0;
                    if (!s) begin
                        if (RELEASE_DEBOUNCE != 0) begin
                            state <= RELEASE_WAIT;
                        end else begin
                            state <= IDLE;
                            level <= 1'b0;
                            fall  <= 1'b1;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (s) begin
                        state <= HIGH;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        level <= 1'b0;
                        fall  <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/debouncer_multi.sv
// Multi-channel debouncer: fans the buses out to independent channels
// and registers AnyRise alongside the per-channel rise pulses.
module debouncer_multi
    import debounce_pkg::*;
#(
    parameter int CHANNELS         = 4,
    parameter int DELAY_CYCLES     = 1000000,
    parameter int SYNC_STAGES      = 2,
    parameter int RELEASE_DEBOUNCE = 1
) (
    input  logic                CLOCK,
    input  logic                Reset,
    input  logic [CHANNELS-1:0] InputPulse,
    output logic [CHANNELS-1:0] DebouncedLevel,
    output logic [CHANNELS-1:0] RisePulse,
    output logic [CHANNELS-1:0] FallPulse,
    output logic                AnyRise
);

    logic [CHANNELS-1:0] rise_next;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .DELAY_CYCLES     (DELAY_CYCLES),
            .SYNC_STAGES      (SYNC_STAGES),
            .RELEASE_DEBOUNCE (RELEASE_DEBOUNCE)
        ) u_ch (
            .CLOCK     (CLOCK),
            .Reset     (Reset),
            .raw       (InputPulse[i]),
            .level     (DebouncedLevel[i]),
            .rise      (RisePulse[i]),
            .fall      (FallPulse[i]),
            .rise_next (rise_next[i])
        );
    end

    // Registered from next-state terms so it lines up with RisePulse.
    always_ff @(posedge CLOCK) begin
        if (Reset) begin
            AnyRise <= 1'b0;
        end else begin
            AnyRise <= |rise_next;
        end
    end

endmodule

// File: tb/tb_debouncer_multi.sv
// Bench for debouncer_multi: directed scenarios plus random toggling,
// checked against a run-length model of the debounce rule.
module tb_debouncer_multi;

    localparam int CH  = 4;
    localparam int DLY = 4;
    localparam int SYN = 2;

    logic          CLOCK = 1'b0;
    logic          Reset = 1'b1;
    logic [CH-1:0] in_a  = '0;
    logic [CH-1:0] in_b  = '0;
    logic [CH-1:0] lvl_a, rise_a, fall_a;
    logic [CH-1:0] lvl_b, rise_b, fall_b;
    logic          any_a, any_b;

    int checks   = 0;
    int failures = 0;

    // Model: raw samples per channel, run of samples disagreeing with level.
    bit hist    [2][CH][SYN];
    int run_len [2][CH];
    bit m_lvl   [2][CH];
    bit m_rise  [2][CH];
    bit m_fall  [2][CH];
    int rise_seen [CH];
    int n;

    always #5 CLOCK = ~CLOCK;

    debouncer_multi #(
        .CHANNELS(CH), .DELAY_CYCLES(DLY),
        .SYNC_STAGES(SYN), .RELEASE_DEBOUNCE(1)
    ) dut_a (
        .CLOCK(CLOCK), .Reset(Reset), .InputPulse(in_a),
        .DebouncedLevel(lvl_a), .RisePulse(rise_a),
        .FallPulse(fall_a), .AnyRise(any_a)
    );

    debouncer_multi #(
        .CHANNELS(CH), .DELAY_CYCLES(DLY),
        .SYNC_STAGES(SYN), .RELEASE_DEBOUNCE(0)
    ) dut_b (
        .CLOCK(CLOCK), .Reset(Reset), .InputPulse(in_b),
        .DebouncedLevel(lvl_b), .RisePulse(rise_b),
        .FallPulse(fall_b), .AnyRise(any_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CH-1:0] pack(input int m, input int sel);
        logic [CH-1:0] v;
        v = '0;
        for (int c = 0; c < CH; c++) begin
            if (sel == 0)      v[c] = m_lvl[m][c];
            else if (sel == 1) v[c] = m_rise[m][c];
            else               v[c] = m_fall[m][c];
        end
        return v;
    endfunction

    // A level change is accepted once the synchronised input has disagreed
    // with the level for DLY+1 consecutive edges (1 edge for immediate release).
    task automatic model_step();
        bit s, r;
        int thr;
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < CH; c++) begin
                m_rise[m][c] = 1'b0;
                m_fall[m][c] = 1'b0;
                if (Reset) begin
                    for (int k = 0; k < SYN; k++) hist[m][c][k] = 1'b0;
                    run_len[m][c] = 0;
                    m_lvl[m][c]   = 1'b0;
                end else begin
                    r = (m == 0) ? in_a[c] : in_b[c];
                    s = hist[m][c][SYN-1];
                    for (int k = SYN - 1; k > 0; k--) hist[m][c][k] = hist[m][c][k-1];
                    hist[m][c][0] = r;
                    if (s != m_lvl[m][c]) begin
                        run_len[m][c]++;
                        thr = (m == 1 && m_lvl[m][c]) ? 1 : DLY + 1;
                        if (run_len[m][c] >= thr) begin
                            m_lvl[m][c]   = s;
                            run_len[m][c] = 0;
                            if (s) m_rise[m][c] = 1'b1;
                            else   m_fall[m][c] = 1'b1;
                        end
                    end else begin
                        run_len[m][c] = 0;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        model_step();
        @(negedge CLOCK);
        chk("level_a", lvl_a,  pack(0, 0));
        chk("rise_a",  rise_a, pack(0, 1));
        chk("fall_a",  fall_a, pack(0, 2));
        chk("any_a",   any_a,  |pack(0, 1));
        chk("level_b", lvl_b,  pack(1, 0));
        chk("rise_b",  rise_b, pack(1, 1));
        chk("fall_b",  fall_b, pack(1, 2));
        chk("any_b",   any_b,  |pack(1, 1));
        for (int c = 0; c < CH; c++) begin
            if (rise_a[c]) rise_seen[c]++;
        end
    endtask

    task automatic edges_until(input bit imm, input int ch,
                               input bit val, output int cnt);
        logic lv;
        cnt = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            lv = imm ? lvl_b[ch] : lvl_a[ch];
            if (lv === val) begin
                cnt = k;
                break;
            end
        end
    endtask

    initial begin
        for (int c = 0; c < CH; c++) rise_seen[c] = 0;

        Reset = 1'b1;
        tick();
        tick();
        chk("rst_level", lvl_a, 0);
        chk("rst_rise",  rise_a, 0);
        chk("rst_fall",  fall_a, 0);
        chk("rst_any",   any_a, 0);
        Reset = 1'b0;
        repeat (3) tick();

        // clean press on channel 0
        in_a[0] = 1'b1;
        edges_until(0, 0, 1'b1, n);
        chk("press_latency", n, 7);
        chk("press_rise", rise_a, 4'b0001);
        chk("press_any", any_a, 1);
        tick();
        chk("press_rise_once", rise_a, 0);
        chk("press_any_once", any_a, 0);
        chk("press_others", lvl_a, 4'b0001);

        // bounce on channel 1: 3 high, 1 low, then held
        for (int c = 0; c < CH; c++) rise_seen[c] = 0;
        in_a[1] = 1'b1;
        repeat (3) tick();
        in_a[1] = 1'b0;
        tick();
        in_a[1] = 1'b1;
        edges_until(0, 1, 1'b1, n);
        chk("bounce_latency", n, 7);
        chk("bounce_rises", rise_seen[1], 1);

        // release bounce on channel 1, then a real release
        in_a[1] = 1'b0;
        repeat (2) tick();
        in_a[1] = 1'b1;
        repeat (8) tick();
        chk("release_hold", lvl_a[1], 1);
        in_a[1] = 1'b0;
        edges_until(0, 1, 1'b0, n);
        chk("release_latency", n, 7);
        chk("release_fall", fall_a, 4'b0010);
        tick();
        chk("release_fall_once", fall_a, 0);

        // immediate release instance
        in_b[0] = 1'b1;
        edges_until(1, 0, 1'b1, n);
        chk("imm_press", n, 7);
        in_b[0] = 1'b0;
        edges_until(1, 0, 1'b0, n);
        chk("imm_release", n, 3);
        chk("imm_fall", fall_b, 4'b0001);

        // all channels together
        in_a = '0;
        repeat (12) tick();
        in_a = 4'hF;
        edges_until(0, 0, 1'b1, n);
        chk("simul_latency", n, 7);
        chk("simul_rise", rise_a, 4'hF);
        chk("simul_any", any_a, 1);
        tick();
        chk("simul_any_once", any_a, 0);
        chk("simul_rise_once", rise_a, 0);

        // reset during PRESS_WAIT on channel 2
        in_a = '0;
        repeat (12) tick();
        in_a[2] = 1'b1;
        repeat (4) tick();
        Reset = 1'b1;
        tick();
        chk("rst_mid_level", lvl_a, 0);
        chk("rst_mid_rise", rise_a, 0);
        chk("rst_mid_fall", fall_a, 0);
        chk("rst_mid_any", any_a, 0);
        Reset = 1'b0;
        for (int c = 0; c < CH; c++) rise_seen[c] = 0;
        edges_until(0, 2, 1'b1, n);
        chk("rst_fresh_latency", n, 7);
        chk("rst_fresh_rises", rise_seen[2], 1);

        // random toggling with occasional reset
        repeat (3000) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 9) == 0) in_a[c] = ~in_a[c];
                if ($urandom_range(0, 9) == 0) in_b[c] = ~in_b[c];
            end
            Reset = ($urandom_range(0, 599) == 0);
            tick();
        end
        Reset = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/debouncer_multi.md
Name: debouncer_multi

Overview:
- Parametrised, multi-channel successor to the team's single-switch debouncer.
- Each channel synchronises a raw mechanical input and debounces both press and release with its own timer.
- Each channel outputs a clean level plus one-cycle rise and fall pulses.
- Sits between board buttons/switches and control FSMs, e.g. the stopwatch start/stop/clear buttons.

Parameters:
- CHANNELS, 4: number of independent inputs; must be ≥1.
- DELAY_CYCLES, 1000000: cycles the synchronised input must stay stable before a change is accepted; must be ≥1.
- SYNC_STAGES, 2: depth of the input synchroniser flop chain; must be ≥2.
- RELEASE_DEBOUNCE, 1: 1 = release debounced like press; 0 = release accepted immediately, one clock after the synchronised low.

Ports:
- CLOCK, in, 1: system clock.
- Reset, in, 1: synchronous, active-high reset; clock CLOCK.
- InputPulse, in, CHANNELS: raw asynchronous switch inputs, active-high.
- DebouncedLevel, out, CHANNELS: debounced level per channel.
- RisePulse, out, CHANNELS: one-cycle pulse when a channel's DebouncedLevel goes 0→1.
- FallPulse, out, CHANNELS: one-cycle pulse when a channel's DebouncedLevel goes 1→0.
- AnyRise, out, 1: OR of RisePulse, registered in the same cycle as RisePulse with no extra latency.

Behaviour:
- All outputs are registered.
- Reset (sampled on a CLOCK edge with Reset=1): every synchroniser flop, state, counter and output is cleared to 0; every channel state goes to IDLE.
  - Reset mid-debounce discards the partial count and produces no pulses.
  - An input already high when Reset deasserts is treated as a fresh press, so RisePulse fires after the full latency.
- Synchroniser: per channel, SYNC_STAGES flops; `s` denotes the last stage.
- Counter: per channel, width max(1, clog2(DELAY_CYCLES)); it never wraps.
- Channel FSM, 4 states:
  - IDLE (level 0): s=1 → PRESS_WAIT, cnt←0.
  - PRESS_WAIT (level 0):
    - s=0 → IDLE (glitch rejected, no pulse).
    - Else if cnt==DELAY_CYCLES-1 → HIGH, with DebouncedLevel←1 and RisePulse←1 for one cycle.
    - Else cnt←cnt+1.
  - HIGH (level 1): s=0 →
    - RELEASE_DEBOUNCE=1: RELEASE_WAIT, cnt←0.
    - RELEASE_DEBOUNCE=0: IDLE, with DebouncedLevel←0 and FallPulse←1.
  - RELEASE_WAIT (level 1):
    - s=1 → HIGH (bounce rejected, no pulse).
    - Else if cnt==DELAY_CYCLES-1 → IDLE, with DebouncedLevel←0 and FallPulse←1.
    - Else cnt←cnt+1.
- Latency: with the raw input stable, DebouncedLevel changes exactly SYNC_STAGES+DELAY_CYCLES+1 edges after the first edge that samples the new raw value (edge 1).
  - Immediate release (RELEASE_DEBOUNCE=0): SYNC_STAGES+1 edges.
- The timer is cleared outside the WAIT states.
- Any glitch shorter than DELAY_CYCLES after synchronisation never reaches DebouncedLevel.
- Channels are fully independent; simultaneous events on several channels each produce their own pulses in the same cycle.
- RisePulse and FallPulse of one channel are never high together.
- A pulse lasts exactly one cycle even if the input is held.

Decomposition:
- Package debounce_pkg:
  - State encoding constants IDLE=0, PRESS_WAIT=1, HIGH=2, RELEASE_WAIT=3.
  - Counter-width function clog2-based, minimum 1.
- Sub-module debounce_channel: one synchroniser + FSM + counter with scalar ports.
  - Instantiated CHANNELS times with a generate loop.
  - The top level only fans out the buses and forms AnyRise.

Test Plan:
All cases use CHANNELS=4, DELAY_CYCLES=4, SYNC_STAGES=2, RELEASE_DEBOUNCE=1 unless stated.
- Clean press: InputPulse[0] 0→1 and held.
  - DebouncedLevel[0]=1 after 7 edges.
  - RisePulse[0] and AnyRise high for exactly that one cycle.
  - Other channels stay 0.
- Bounce rejection: InputPulse[1] high 3 cycles, low 1 cycle, then held high.
  - No pulse during the bounce.
  - Level rises 7 edges after the final 0→1 sample.
- Release debounce: from HIGH, drop the input for 2 cycles, restore, then drop and hold.
  - Level stays 1 through the 2-cycle drop.
  - FallPulse one cycle, 7 edges after the final drop.
- Immediate release mode (RELEASE_DEBOUNCE=0): from HIGH, drop the input.
  - Level=0 and FallPulse=1 after 3 edges.
- Simultaneous channels: all 4 inputs rise on the same edge.
  - All RisePulse bits high in the same cycle.
  - AnyRise=1 for exactly one cycle.
- Reset mid-operation: assert Reset during PRESS_WAIT on channel 2 with the input still high.
  - All outputs 0 at the next edge with no pulse.
  - After deassert, level rises 7 edges later with one RisePulse.
